// File: rtl/pipe_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin pipe scheduler.
package pipe_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int TAG_W     = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

  typedef logic [TAG_W-1:0] tag_t;

  // Round-robin successor of a granted index.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pipe_rr_scheduler_if.sv
// Handshake bundle between clients, the scheduler and the shared pipe.
// master: client/pipe side, slave: scheduler side.
interface pipe_rr_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16
);
  import pipe_sched_pkg::*;

  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_rdy;
  logic                   pipe_in_vld;
  logic [WIDTH-1:0]       pipe_in_data;
  logic                   pipe_out_vld;
  logic [OUT_WIDTH-1:0]   pipe_out_data;
  logic [N_REQ-1:0]       rsp_vld;
  logic [OUT_WIDTH-1:0]   rsp_data;
  logic                   busy;
  logic                   err;

  modport master (
    output req_vld, req_data, pipe_out_vld, pipe_out_data,
    input  req_rdy, pipe_in_vld, pipe_in_data, rsp_vld, rsp_data, busy, err
  );

  modport slave (
    input  req_vld, req_data, pipe_out_vld, pipe_out_data,
    output req_rdy, pipe_in_vld, pipe_in_data, rsp_vld, rsp_data, busy, err
  );

endinterface

// File: rtl/pipe_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: search upward from ptr with wrap,
// first requesting index wins. Pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  import pipe_sched_pkg::*;

  int idx;

  // Priority search starting at ptr; at most one grant bit set.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_rr_scheduler.sv
// Shares one fixed-latency pipelined unit among N_REQ requesters. Grants
// round-robin, one issue per cycle, and carries the issuer index alongside
// the unit in a valid/tag shift register so results route back to it.
module pipe_rr_scheduler
  import pipe_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16,
  parameter int LATENCY   = 4
) (
  input logic             clk,
  input logic             rst,
  pipe_rr_scheduler_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  idx_t             ptr;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  idx_t             gnt_idx;
  logic             gnt_vld;
  idx_t             issue_idx;

  logic [LATENCY-1:0] tag_vld;
  idx_t               tag_idx [LATENCY];

  // No grants while reset is held.
  assign arb_req     = bus.req_vld & {N_REQ{~rst}};
  assign bus.req_rdy = gnt;

  rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
    .req     (arb_req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Pointer moves past the winner on every transfer, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= IDX_W'(next_ptr(int'(gnt_idx), N_REQ));
    end
  end

  // Issue register toward the unit; operand holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pipe_in_vld  <= 1'b0;
      bus.pipe_in_data <= '0;
      issue_idx        <= '0;
    end else begin
      bus.pipe_in_vld <= gnt_vld;
      if (gnt_vld) begin
        bus.pipe_in_data <= bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH];
        issue_idx        <= gnt_idx;
      end
    end
  end

  // Tag valids shift every cycle, bubbles included; last stage lines up with pipe_out_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= bus.pipe_in_vld;
      for (int s = 1; s < LATENCY; s++) tag_vld[s] <= tag_vld[s-1];
    end
  end

  // Tag indices ride along without reset; only meaningful where the valid is set.
  always_ff @(posedge clk) begin
    tag_idx[0] <= issue_idx;
    for (int s = 1; s < LATENCY; s++) tag_idx[s] <= tag_idx[s-1];
  end

  // Route a tagged result to its issuer; untagged results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_vld  <= '0;
      bus.rsp_data <= '0;
    end else if (bus.pipe_out_vld && tag_vld[LATENCY-1]) begin
      bus.rsp_vld  <= N_REQ'(1) << tag_idx[LATENCY-1];
      bus.rsp_data <= bus.pipe_out_data;
    end else begin
      bus.rsp_vld  <= '0;
    end
  end

  // Sticky flag for any disagreement between unit output and tag valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err <= 1'b0;
    end else if (bus.pipe_out_vld != tag_vld[LATENCY-1]) begin
      bus.err <= 1'b1;
    end
  end

  assign bus.busy = (|tag_vld) | bus.pipe_in_vld;

endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// Directed bench for pipe_rr_scheduler; models the shared unit as a
// LATENCY-deep shift register computing f(x) = 3x + 7 (16 bits).
module tb_pipe_rr_scheduler;
  import pipe_sched_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int OW  = 16;
  localparam int LAT = 4;
  localparam int RSP_LAT = LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inj = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  pipe_rr_scheduler_if #(.N_REQ(N), .WIDTH(W), .OUT_WIDTH(OW)) bus ();

  pipe_rr_scheduler #(.N_REQ(N), .WIDTH(W), .OUT_WIDTH(OW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] f(input logic [W-1:0] x);
    return OW'(x * 3 + 7);
  endfunction

  // Unit model, reset together with the scheduler.
  logic [LAT-1:0] m_vld;
  logic [OW-1:0]  m_dat [LAT];

  always @(posedge clk) begin
    if (rst) begin
      m_vld <= '0;
    end else begin
      m_vld[0] <= bus.pipe_in_vld;
      m_dat[0] <= f(bus.pipe_in_data);
      for (int s = 1; s < LAT; s++) begin
        m_vld[s] <= m_vld[s-1];
        m_dat[s] <= m_dat[s-1];
      end
    end
  end

  assign bus.pipe_out_vld  = m_vld[LAT-1] | inj;
  assign bus.pipe_out_data = m_dat[LAT-1];

  // Expectation state, indexed by cycle since the last reset.
  int            cyc;
  int            err_from;
  logic [N-1:0]  exp_rsp_vld  [64];
  logic [OW-1:0] exp_rsp_data [64];
  bit            exp_busy     [64];
  bit            exp_pin_vld;
  logic [W-1:0]  exp_pin_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_exp();
    cyc          = 0;
    err_from     = 1000;
    exp_pin_vld  = 1'b0;
    exp_pin_data = '0;
    for (int i = 0; i < 64; i++) begin
      exp_rsp_vld[i]  = '0;
      exp_rsp_data[i] = '0;
      exp_busy[i]     = 1'b0;
    end
  endtask

  // Hold rst for n cycles with the given requests and check the cleared state.
  task automatic do_reset(input int n, input logic [N-1:0] vld);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_vld = vld;
    inj = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_req_rdy", bus.req_rdy, '0);
      chk("rst_rsp_vld", bus.rsp_vld, '0);
      chk("rst_pipe_in_vld", bus.pipe_in_vld, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_err", bus.err, 1'b0);
    end
    rst = 1'b0;
    bus.req_vld = '0;
    clear_exp();
  endtask

  // One clock: drive requests (field i = base+i), check, then record what the grant implies.
  task automatic cycle(input logic [N-1:0] vld, input logic [W-1:0] base,
                       input logic [N-1:0] exp_rdy, input bit inject);
    @(posedge clk); #1;
    bus.req_vld = vld;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = base + W'(i);
    inj = inject;
    #1;
    chk("req_rdy", bus.req_rdy, exp_rdy);
    chk("rsp_vld", bus.rsp_vld, exp_rsp_vld[cyc]);
    if (exp_rsp_vld[cyc] != '0) chk("rsp_data", bus.rsp_data, exp_rsp_data[cyc]);
    chk("pipe_in_vld", bus.pipe_in_vld, exp_pin_vld);
    if (exp_pin_vld) chk("pipe_in_data", bus.pipe_in_data, exp_pin_data);
    chk("busy", bus.busy, exp_busy[cyc]);
    chk("err", bus.err, (cyc >= err_from) ? 1 : 0);
    exp_pin_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        exp_pin_vld  = 1'b1;
        exp_pin_data = base + W'(i);
        exp_rsp_vld[cyc + RSP_LAT]  = exp_rdy;
        exp_rsp_data[cyc + RSP_LAT] = f(base + W'(i));
        for (int d = 1; d <= LAT + 1; d++) exp_busy[cyc + d] = 1'b1;
      end
    end
    if (inject && err_from > cyc + 1) err_from = cyc + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_vld  = '0;
    bus.req_data = '0;
    clear_exp();

    // 1. reset with every requester asserting
    do_reset(3, 4'b1111);

    // 2. single requester 2 with operand 49 -> f(49)=154 six cycles later
    cycle(4'b0100, 32'd47, 4'b0100, 1'b0);
    idle(8);

    // 3. all requesting: grants rotate 0,1,2,3,0,... with a response each cycle
    do_reset(1, 4'b0000);
    for (int k = 0; k < 8; k++)
      cycle(4'b1111, W'((k + 1) * 16), 4'(1 << (k % 4)), 1'b0);
    idle(8);

    // 4. requesters 1 and 3 only: 1, 3, 1, 3; 0 and 2 never granted
    do_reset(1, 4'b0000);
    cycle(4'b1010, 32'd300, 4'b0010, 1'b0);
    cycle(4'b1010, 32'd310, 4'b1000, 1'b0);
    cycle(4'b1010, 32'd320, 4'b0010, 1'b0);
    cycle(4'b1010, 32'd330, 4'b1000, 1'b0);
    idle(8);

    // 5. stray result with nothing in flight: err sticks, no response
    cycle(4'b0000, 32'd0, 4'b0000, 1'b1);
    idle(5);

    // 6. reset with three issues in flight: nothing comes back, pointer back to 0
    do_reset(1, 4'b0000);
    cycle(4'b1111, 32'd500, 4'b0001, 1'b0);
    cycle(4'b1111, 32'd510, 4'b0010, 1'b0);
    cycle(4'b1111, 32'd520, 4'b0100, 1'b0);
    do_reset(1, 4'b0000);
    idle(8);
    cycle(4'b1111, 32'd600, 4'b0001, 1'b0);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
